// File: rtl/hack_alu_serial.sv
// Digit-serial Hack ALU: operands are preprocessed at acceptance,
// then DIGIT bits per cycle flow through a carry-chained add/AND slice.
module hack_alu_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             busy
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = $clog2(NSTEP + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  logic              carry;
  logic [WIDTH-1:0]  xs, ys, acc;
  logic              f_q, no_q;

  logic [WIDTH-1:0]  x_z, y_z, xp, yp;
  logic [DIGIT-1:0]  xd, yd, dig;
  logic [DIGIT:0]    sum;
  logic [WIDTH-1:0]  acc_nx;
  logic              last, accept;

  always_comb begin
    x_z = zx ? '0 : x;
    xp  = nx ? ~x_z : x_z;
    y_z = zy ? '0 : y;
    yp  = ny ? ~y_z : y_z;
  end

  always_comb begin
    xd  = xs[DIGIT-1:0];
    yd  = ys[DIGIT-1:0];
    sum = {1'b0, xd} + {1'b0, yd}
        + {{DIGIT{1'b0}}, carry};
    dig = f_q ? sum[DIGIT-1:0] : (xd & yd);
    if (no_q) dig = ~dig;
    // new digit enters at the MSB end
    acc_nx = (acc >> DIGIT)
           | (WIDTH'(dig) << (WIDTH - DIGIT));
  end

  assign last      = (cnt == CW'(NSTEP - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      xs    <= '0;
      ys    <= '0;
      acc   <= '0;
      f_q   <= 1'b0;
      no_q  <= 1'b0;
      out   <= '0;
      zr    <= 1'b0;
      ng    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        xs    <= xp;
        ys    <= yp;
        f_q   <= f;
        no_q  <= no;
        carry <= 1'b0;
        cnt   <= '0;
      end else if (state == RUN) begin
        xs    <= xs >> DIGIT;
        ys    <= ys >> DIGIT;
        acc   <= acc_nx;
        carry <= sum[DIGIT];
        cnt   <= cnt + CW'(1);
        if (last) begin
          out <= acc_nx;
          zr  <= (acc_nx == '0);
          ng  <= acc_nx[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_hack_alu_serial.sv
// Bench for hack_alu_serial: table vectors, random ops against the
// combinational Hack equations, and handshake/reset corner sequences.
module tb_hack_alu_serial;

  typedef struct {
    logic [15:0] o;
    logic        zr;
    logic        ng;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  c;
    exp_t        e;
  } vec_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [15:0] xi = 0, yi = 0;
  logic [5:0]  ctl = 0;

  logic        iv = 0, ir, ov, ordy = 0, zr, ng, busy;
  logic [15:0] o;
  logic        iv2 = 0, ir2, ov2, ordy2 = 0, zr2, ng2, busy2;
  logic [15:0] o2;
  logic        iv3 = 0, ir3, ov3, ordy3 = 0, zr3, ng3, busy3;
  logic [7:0]  o3;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  hack_alu_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .reset_n(rst_n), .in_valid(iv), .in_ready(ir),
    .x(xi), .y(yi), .zx(ctl[5]), .nx(ctl[4]), .zy(ctl[3]),
    .ny(ctl[2]), .f(ctl[1]), .no(ctl[0]), .out_valid(ov),
    .out_ready(ordy), .out(o), .zr(zr), .ng(ng), .busy(busy));

  hack_alu_serial #(.WIDTH(16), .DIGIT(16)) dut2 (
    .clk(clk), .reset_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .x(xi), .y(yi), .zx(ctl[5]), .nx(ctl[4]), .zy(ctl[3]),
    .ny(ctl[2]), .f(ctl[1]), .no(ctl[0]), .out_valid(ov2),
    .out_ready(ordy2), .out(o2), .zr(zr2), .ng(ng2), .busy(busy2));

  hack_alu_serial #(.WIDTH(8), .DIGIT(2)) dut3 (
    .clk(clk), .reset_n(rst_n), .in_valid(iv3), .in_ready(ir3),
    .x(xi[7:0]), .y(yi[7:0]), .zx(ctl[5]), .nx(ctl[4]),
    .zy(ctl[3]), .ny(ctl[2]), .f(ctl[1]), .no(ctl[0]),
    .out_valid(ov3), .out_ready(ordy3), .out(o3), .zr(zr3),
    .ng(ng3), .busy(busy3));

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [15:0] hack(input logic [15:0] a,
                                       input logic [15:0] b,
                                       input logic [5:0] c);
    logic [15:0] r;
    if (c[5]) a = 16'h0;
    if (c[4]) a = ~a;
    if (c[3]) b = 16'h0;
    if (c[2]) b = ~b;
    r = c[1] ? a + b : a & b;
    if (c[0]) r = ~r;
    return r;
  endfunction

  function automatic exp_t mk(input logic [15:0] r);
    exp_t e;
    e.o  = r;
    e.zr = (r == 16'h0);
    e.ng = r[15];
    return e;
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [5:0] c, input exp_t e);
    int   n;
    exp_t g;
    n = 0;
    @(negedge clk);
    while (!ir && n < 20) begin @(negedge clk); n++; end
    check("in_ready", ir, 1);
    iv = 1; xi = a; yi = b; ctl = c;
    @(negedge clk);
    iv = 0;
    sb.push_back(e);
    n = 0;
    while (!ov && n < 40) begin @(negedge clk); n++; end
    check("latency", n, 4);
    g = sb.pop_front();
    check("out", o, g.o);
    check("zr", zr, g.zr);
    check("ng", ng, g.ng);
    ordy = 1;
    @(negedge clk);
    ordy = 0;
    check("release", {ov, ir}, 2'b01);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [5:0] c);
    int         n;
    logic [7:0] r;
    r = hack({8'h0, a}, {8'h0, b}, c)[7:0];
    @(negedge clk);
    iv3 = 1; xi = {8'h0, a}; yi = {8'h0, b}; ctl = c;
    @(negedge clk);
    iv3 = 0;
    n = 0;
    while (!ov3 && n < 40) begin @(negedge clk); n++; end
    check("w8_latency", n, 4);
    check("w8_out", o3, r);
    check("w8_flags", {zr3, ng3}, {r == 8'h0, r[7]});
    ordy3 = 1;
    @(negedge clk);
    ordy3 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tab[7];
    exp_t g;
    int   n;
    logic [15:0] a, b;
    logic [5:0]  c;

    tab[0] = '{16'h1234, 16'h0F0F, 6'b000010, '{16'h2143, 1'b0, 1'b0}};
    tab[1] = '{16'h1234, 16'h0F0F, 6'b000000, '{16'h0204, 1'b0, 1'b0}};
    tab[2] = '{16'h0FFF, 16'h0001, 6'b000010, '{16'h1000, 1'b0, 1'b0}};
    tab[3] = '{16'hFFFF, 16'h0001, 6'b000010, '{16'h0000, 1'b1, 1'b0}};
    tab[4] = '{16'h0005, 16'h0007, 6'b010011, '{16'hFFFE, 1'b0, 1'b1}};
    tab[5] = '{16'h1234, 16'h5678, 6'b101010, '{16'h0000, 1'b1, 1'b0}};
    tab[6] = '{16'h1234, 16'h5678, 6'b111010, '{16'hFFFF, 1'b0, 1'b1}};

    @(negedge clk);
    check("rst_out", o, 16'h0);
    check("rst_flags", {zr, ng}, 2'b00);
    check("rst_hs", {ov, busy, ir}, 3'b001);
    rst_n = 1;

    for (int i = 0; i < 7; i++)
      run_op(tab[i].a, tab[i].b, tab[i].c, tab[i].e);

    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 6'($urandom_range(0, 63));
      run_op(a, b, c, mk(hack(a, b, c)));
    end

    // backpressure: hold result while new operands are offered
    @(negedge clk);
    iv = 1; xi = 16'h00AA; yi = 16'h0055; ctl = 6'b000010;
    @(negedge clk);
    iv = 0;
    sb.push_back('{16'h00FF, 1'b0, 1'b0});
    n = 0;
    while (!ov && n < 40) begin @(negedge clk); n++; end
    check("bp_latency", n, 4);
    g = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {o, zr, ng}, {g.o, g.zr, g.ng});
      check("bp_hs", {ov, ir}, 2'b10);
      iv = 1; xi = 16'($urandom); yi = 16'($urandom);
      ctl = 6'b000010;
      @(negedge clk);
    end
    iv = 0;
    ordy = 1;
    @(negedge clk);
    ordy = 0;
    check("bp_release", {ov, ir, busy}, 3'b010);
    check("bp_retain", o, g.o);
    run_op(tab[1].a, tab[1].b, tab[1].c, tab[1].e);

    // reset in the middle of RUN
    @(negedge clk);
    iv = 1; xi = 16'h1234; yi = 16'h0F0F; ctl = 6'b000010;
    @(negedge clk);
    iv = 0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n = 0;
    #1;
    check("mid_rst_hs", {ov, busy, ir}, 3'b001);
    check("mid_rst_out", {o, zr, ng}, 18'h0);
    @(negedge clk);
    rst_n = 1;
    run_op(16'h0003, 16'h0004, 6'b000010, mk(16'h0007));

    // DIGIT == WIDTH: single RUN cycle
    @(negedge clk);
    iv2 = 1; xi = 16'h1234; yi = 16'h0F0F; ctl = 6'b000010;
    @(negedge clk);
    iv2 = 0;
    check("d16_run", {ov2, busy2}, 2'b01);
    @(negedge clk);
    check("d16_valid", ov2, 1);
    check("d16_out", o2, 16'h2143);
    ordy2 = 1;
    @(negedge clk);
    ordy2 = 0;
    check("d16_release", {ov2, ir2}, 2'b01);

    // WIDTH 8, DIGIT 2
    run8(8'hFF, 8'h01, 6'b000010);
    for (int i = 0; i < 4; i++)
      run8(8'($urandom), 8'($urandom), 6'($urandom_range(0, 63)));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_alu_serial.md
Name: hack_alu_serial

Overview:
- Parametrised, digit-serial successor to the combinational Hack ALU.
- Uses the same six control bits (zx, nx, zy, ny, f, no) and the same zr/ng flags.
- Operand width is WIDTH; each clock processes DIGIT bits through a carry-chained adder/AND slice.
- Sits between operand sources and the register file, with valid/ready handshakes on both sides; trades latency for a narrow datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly. NSTEP = WIDTH/DIGIT.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation.
- x  in  WIDTH  operand x.
- y  in  WIDTH  operand y.
- zx, nx, zy, ny, f, no  in  1 each  Hack ALU control bits.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- zr  out  1  result == 0.
- ng  out  1  result MSB set.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync deassert): state IDLE, step counter 0, carry 0.
  - Outputs during/after reset: out=0, zr=0, ng=0, out_valid=0, busy=0, in_ready=1.
  - Reset mid-operation discards the operation; no partial result is ever presented.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE), combinational from state only.
  - out_valid = (state==DONE), registered.
- IDLE → RUN on in_valid && in_ready.
  - At acceptance, latch preprocessed operands: xp = nx ? ~(zx ? 0 : x) : (zx ? 0 : x); yp likewise with zy/ny.
  - Also latch f and no. Clear carry and counter.
  - x, y and control bits are ignored at all other times.
- RUN: one digit per cycle, LSB digit first.
  - f=1: digit = xp[d] + yp[d] + carry; carry register updated.
  - f=0: digit = xp[d] & yp[d]; carry unused.
  - Digit inverted if no=1.
  - Result digit enters the result shift register from the MSB side; operands shift right by DIGIT.
  - Counter increments each cycle. After NSTEP RUN cycles the state goes to DONE.
- Arithmetic: modulo 2^WIDTH. Carry out of the MSB digit is discarded.
- DONE:
  - out, zr = (out == 0) and ng = out[WIDTH-1] are registered together on the RUN → DONE edge, and stay stable while out_valid=1.
  - Leave for IDLE on out_ready=1. Hold indefinitely while out_ready=0.
  - in_valid is ignored in DONE (in_ready=0); the next operation is accepted at the earliest one cycle after the result handshake.
- Latency: acceptance edge at cycle k → out_valid=1 after edge k+NSTEP.
  - Best-case throughput is one operation per NSTEP+2 cycles.
  - DIGIT==WIDTH gives NSTEP=1 (single RUN cycle).
- After the result handshake, out/zr/ng retain their last values until the next completion. Consumers qualify them with out_valid only.
- busy = 1 in RUN and DONE.

Test Plan:
All scenarios use WIDTH=16, DIGIT=4 unless noted. Controls are listed as zx nx zy ny f no.

1. x+y, controls 000010, x=0x1234, y=0x0F0F → after 4 RUN cycles: out_valid=1, out=0x2143, zr=0, ng=0. With controls 000000 (x&y), same operands → out=0x0204.
2. Cross-digit carry and wrap, controls 000010:
   - x=0x0FFF, y=0x0001 → out=0x1000.
   - x=0xFFFF, y=0x0001 → out=0x0000, zr=1, ng=0.
3. x−y, controls 010011, x=5, y=7 → out=0xFFFE, ng=1, zr=0. Constant 0, controls 101010 → out=0, zr=1. Constant −1, controls 111010 → out=0xFFFF, ng=1.
4. Backpressure:
   - Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands → out/zr/ng unchanged, in_ready=0, no acceptance.
   - Raise out_ready → IDLE next cycle with in_ready=1; the following operation computes correctly.
5. Reset mid-RUN: assert reset_n=0 after 2 RUN cycles → immediately out_valid=0, busy=0, in_ready=1, out=0. Release reset, issue x+y (x=3, y=4) → out=0x0007.
6. Parameter sweep: WIDTH=16, DIGIT=16 → out_valid one cycle after the RUN cycle. WIDTH=8, DIGIT=2 → 0xFF+0x01=0x00, zr=1. Random controls/operands compared against the combinational Hack ALU equations.
